// File: rtl/integration_sw_debounce_pkg.sv
// Shared constants and types for the slide-switch conditioning block.
// The PIO instance reads the same switch width and debounce timing from here.
package integration_sw_debounce_pkg;

    localparam int unsigned SwWidth          = 16;
    localparam int unsigned SwSyncStages     = 2;
    localparam int unsigned SwDebounceCycles = 1000000;
    localparam int unsigned SwCntW           = 20;

    typedef enum logic {
        StStable   = 1'b0,
        StCounting = 1'b1
    } db_state_e;

endpackage

// File: rtl/integration_sw_debounce_if.sv
// Switch bundle between the raw board pins and the debounced PIO side.
// master drives the raw levels; slave is the debouncer producing clean levels and pulses.
interface integration_sw_debounce_if
    import integration_sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH = SwWidth
);

    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    modport master (
        output sw_raw,
        input  sw_clean,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    modport slave (
        input  sw_raw,
        output sw_clean,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );

endinterface

// File: rtl/integration_debounce_bit.sv
// One switch bit: synchroniser chain, stability counter and STABLE/COUNTING FSM.
// A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module integration_debounce_bit
    import integration_sw_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SwSyncStages,
    parameter int unsigned DEBOUNCE_CYCLES = SwDebounceCycles,
    parameter int unsigned CNT_W           = SwCntW
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw_i,
    output logic sw_clean_o,
    output logic sw_rise_o,
    output logic sw_fall_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sw_sync;
    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw_i};
        end
    end

    assign sw_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StStable;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            StStable: begin
                if (sw_sync == clean_q) begin
                    cnt_d = '0;
                end else if (DEBOUNCE_CYCLES == 1) begin
                    // Single-cycle qualification: no filtering, accept right away.
                    accept = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = StCounting;
                end
            end
            StCounting: begin
                if (sw_sync == clean_q) begin
                    cnt_d   = '0;
                    state_d = StStable;
                end else if (cnt_q == CntLast) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = StStable;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StStable;
            end
        endcase
    end

    always_comb begin
        clean_d = accept ? sw_sync : clean_q;
        rise_d  = accept & sw_sync;
        fall_d  = accept & ~sw_sync;
    end

    assign sw_clean_o = clean_q;
    assign sw_rise_o  = rise_q;
    assign sw_fall_o  = fall_q;

endmodule

// File: rtl/integration_sw_debounce.sv
// Conditions the board slide switches ahead of the switch PIO: per-bit debounce
// instances plus a combined change pulse for future edge-capture logic.
module integration_sw_debounce
    import integration_sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = SwWidth,
    parameter int unsigned SYNC_STAGES     = SwSyncStages,
    parameter int unsigned DEBOUNCE_CYCLES = SwDebounceCycles,
    parameter int unsigned CNT_W           = SwCntW
) (
    input  logic                        clk,
    input  logic                        reset,
    integration_sw_debounce_if.slave    sw_if
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        integration_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .sw_raw_i   (sw_if.sw_raw[i]),
            .sw_clean_o (sw_if.sw_clean[i]),
            .sw_rise_o  (sw_if.sw_rise[i]),
            .sw_fall_o  (sw_if.sw_fall[i])
        );
    end

    // Pulses are registered per bit, so this OR is glitch-free and one cycle wide.
    assign sw_if.sw_changed = |(sw_if.sw_rise | sw_if.sw_fall);

endmodule

// File: tb/tb_integration_sw_debounce.sv
// Self-checking bench for integration_sw_debounce with short debounce timing.
// A sample-history reference model predicts clean levels and pulses every cycle.
module tb_integration_sw_debounce;

    localparam int unsigned W    = 16;
    localparam int unsigned SYNC = 2;
    localparam int unsigned DC   = 8;
    localparam int unsigned CW   = 4;
    localparam int unsigned HLEN = SYNC + DC - 1;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    integration_sw_debounce_if #(.WIDTH(W)) sw_if ();

    integration_sw_debounce #(
        .WIDTH           (W),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw_if (sw_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: m_hist[j] holds raw sampled j+1 edges ago. The synchronised
    // value seen by the filter at this edge is m_hist[SYNC-1]; a bit flips when the
    // last DC synchronised samples all disagree with its clean level.
    logic [W-1:0] m_hist [HLEN];
    logic [W-1:0] m_clean, m_rise, m_fall;
    logic         m_chg;

    always @(posedge clk or posedge reset) begin : model
        logic [W-1:0] nxt;
        logic         all_diff;
        if (reset) begin
            for (int j = 0; j < HLEN; j++) m_hist[j] = '0;
            m_clean = '0;
            m_rise  = '0;
            m_fall  = '0;
        end else begin
            nxt    = m_clean;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DC; k++) begin
                    if (m_hist[SYNC-1+k][i] == m_clean[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    nxt[i]    = ~m_clean[i];
                    m_rise[i] = ~m_clean[i];
                    m_fall[i] = m_clean[i];
                end
            end
            m_clean = nxt;
            for (int j = HLEN - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = sw_if.sw_raw;
        end
        m_chg = |(m_rise | m_fall);
    end

    task automatic test_reset();
        reset = 1'b1;
        sw_if.sw_raw = 16'hFFFF;
        repeat (3) @(negedge clk);
        total++;
        if ({sw_if.sw_clean, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_changed} !== '0) begin
            bad++;
            $display("FAIL reset_outputs clean=%h rise=%h fall=%h chg=%b want all 0",
                     sw_if.sw_clean, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_changed);
        end
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            total++;
            if ({sw_if.sw_clean, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_changed} !==
                {m_clean, m_rise, m_fall, m_chg}) begin
                bad++;
                $display("FAIL reset_model c=%0d clean=%h/%h rise=%h/%h fall=%h/%h", c,
                         sw_if.sw_clean, m_clean, sw_if.sw_rise, m_rise, sw_if.sw_fall, m_fall);
            end
            if (c == 9) begin
                total++;
                if (sw_if.sw_clean !== 16'h0000) begin
                    bad++;
                    $display("FAIL reset_early clean=%h want 0000", sw_if.sw_clean);
                end
            end
            if (c == 10) begin
                total++;
                if (sw_if.sw_clean !== 16'hFFFF || sw_if.sw_rise !== 16'hFFFF ||
                    sw_if.sw_changed !== 1'b1) begin
                    bad++;
                    $display("FAIL reset_qualify clean=%h rise=%h chg=%b want FFFF FFFF 1",
                             sw_if.sw_clean, sw_if.sw_rise, sw_if.sw_changed);
                end
            end
            if (c == 11) begin
                total++;
                if (sw_if.sw_rise !== 16'h0000 || sw_if.sw_changed !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_pulse_width rise=%h chg=%b want 0000 0",
                             sw_if.sw_rise, sw_if.sw_changed);
                end
            end
        end
    endtask

    task automatic test_single_rise();
        int n_rise = 0;
        int n_chg  = 0;
        sw_if.sw_raw = 16'h0000;
        for (int c = -11; c <= 14; c++) begin
            @(negedge clk);
            total++;
            if ({sw_if.sw_clean, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_changed} !==
                {m_clean, m_rise, m_fall, m_chg}) begin
                bad++;
                $display("FAIL rise_model c=%0d clean=%h/%h rise=%h/%h fall=%h/%h", c,
                         sw_if.sw_clean, m_clean, sw_if.sw_rise, m_rise, sw_if.sw_fall, m_fall);
            end
            if (c > 0) begin
                n_rise += int'(sw_if.sw_rise[3]);
                n_chg  += int'(sw_if.sw_changed);
            end
            if (c == 9) begin
                total++;
                if (sw_if.sw_clean !== 16'h0000) begin
                    bad++;
                    $display("FAIL rise_early clean=%h want 0000", sw_if.sw_clean);
                end
            end
            if (c == 10) begin
                total++;
                if (sw_if.sw_clean !== 16'h0008 || sw_if.sw_rise !== 16'h0008) begin
                    bad++;
                    $display("FAIL rise_bit3 clean=%h rise=%h want 0008 0008",
                             sw_if.sw_clean, sw_if.sw_rise);
                end
            end
            if (c == 0) sw_if.sw_raw = 16'h0008;
        end
        total++;
        if (n_rise != 1 || n_chg != 1) begin
            bad++;
            $display("FAIL rise_counts rise3=%0d chg=%0d want 1 1", n_rise, n_chg);
        end
    endtask

    task automatic test_glitch();
        int n_chg = 0;
        sw_if.sw_raw = 16'h0000;
        for (int c = -11; c <= 20; c++) begin
            @(negedge clk);
            total++;
            if ({sw_if.sw_clean, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_changed} !==
                {m_clean, m_rise, m_fall, m_chg}) begin
                bad++;
                $display("FAIL glitch_model c=%0d clean=%h/%h rise=%h/%h fall=%h/%h", c,
                         sw_if.sw_clean, m_clean, sw_if.sw_rise, m_rise, sw_if.sw_fall, m_fall);
            end
            if (c > 0) n_chg += int'(sw_if.sw_changed);
            if (c == 0) sw_if.sw_raw = 16'h0020;
            if (c == 7) sw_if.sw_raw = 16'h0000;
        end
        total++;
        if (sw_if.sw_clean[5] !== 1'b0 || n_chg != 0) begin
            bad++;
            $display("FAIL glitch_discard clean5=%b chg=%0d want 0 0", sw_if.sw_clean[5], n_chg);
        end
    endtask

    task automatic test_bounce();
        int t_rise = -1;
        sw_if.sw_raw = 16'h0000;
        for (int c = -11; c <= 20; c++) begin
            @(negedge clk);
            total++;
            if ({sw_if.sw_clean, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_changed} !==
                {m_clean, m_rise, m_fall, m_chg}) begin
                bad++;
                $display("FAIL bounce_model c=%0d clean=%h/%h rise=%h/%h fall=%h/%h", c,
                         sw_if.sw_clean, m_clean, sw_if.sw_rise, m_rise, sw_if.sw_fall, m_fall);
            end
            if (c > 0 && sw_if.sw_rise[0] === 1'b1) t_rise = c;
            if (c == 0) sw_if.sw_raw = 16'h0001;
            if (c == 3) sw_if.sw_raw = 16'h0000;
            if (c == 6) sw_if.sw_raw = 16'h0001;
        end
        total++;
        if (t_rise != 16) begin
            bad++;
            $display("FAIL bounce_latency rise_at=%0d want 16", t_rise);
        end
    endtask

    task automatic test_staggered();
        int t15 = -1;
        int t2  = -1;
        int n_chg = 0;
        sw_if.sw_raw = 16'h0000;
        for (int c = -11; c <= 20; c++) begin
            @(negedge clk);
            total++;
            if ({sw_if.sw_clean, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_changed} !==
                {m_clean, m_rise, m_fall, m_chg}) begin
                bad++;
                $display("FAIL stagger_model c=%0d clean=%h/%h rise=%h/%h fall=%h/%h", c,
                         sw_if.sw_clean, m_clean, sw_if.sw_rise, m_rise, sw_if.sw_fall, m_fall);
            end
            if (c > 0) begin
                if (sw_if.sw_rise[15] === 1'b1) t15 = c;
                if (sw_if.sw_rise[2] === 1'b1) t2 = c;
                n_chg += int'(sw_if.sw_changed);
            end
            if (c == 0) sw_if.sw_raw = 16'h8000;
            if (c == 4) sw_if.sw_raw = 16'h8004;
        end
        total++;
        if (t15 != 10 || t2 != 14 || n_chg != 2) begin
            bad++;
            $display("FAIL stagger_pulses t15=%0d t2=%0d chg=%0d want 10 14 2", t15, t2, n_chg);
        end
    endtask

    task automatic test_reset_mid_count();
        sw_if.sw_raw = 16'hFF7F;
        for (int c = -11; c <= 7; c++) begin
            @(negedge clk);
            total++;
            if ({sw_if.sw_clean, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_changed} !==
                {m_clean, m_rise, m_fall, m_chg}) begin
                bad++;
                $display("FAIL midrst_model c=%0d clean=%h/%h rise=%h/%h fall=%h/%h", c,
                         sw_if.sw_clean, m_clean, sw_if.sw_rise, m_rise, sw_if.sw_fall, m_fall);
            end
            if (c == 0) sw_if.sw_raw = 16'hFFFF;
        end
        // Bit 7 has now seen five disagreeing samples.
        reset = 1'b1;
        #1;
        total++;
        if (sw_if.sw_clean !== 16'h0000 || sw_if.sw_rise !== 16'h0000 ||
            sw_if.sw_changed !== 1'b0) begin
            bad++;
            $display("FAIL midrst_clear clean=%h rise=%h chg=%b want 0000 0000 0",
                     sw_if.sw_clean, sw_if.sw_rise, sw_if.sw_changed);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            total++;
            if ({sw_if.sw_clean, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_changed} !==
                {m_clean, m_rise, m_fall, m_chg}) begin
                bad++;
                $display("FAIL midrst_requal_model c=%0d clean=%h/%h rise=%h/%h", c,
                         sw_if.sw_clean, m_clean, sw_if.sw_rise, m_rise);
            end
            if (c == 10) begin
                total++;
                if (sw_if.sw_clean !== 16'hFFFF || sw_if.sw_rise !== 16'hFFFF) begin
                    bad++;
                    $display("FAIL midrst_requal clean=%h rise=%h want FFFF FFFF",
                             sw_if.sw_clean, sw_if.sw_rise);
                end
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            total++;
            if ({sw_if.sw_clean, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_changed} !==
                {m_clean, m_rise, m_fall, m_chg}) begin
                bad++;
                $display("FAIL random_model c=%0d clean=%h/%h rise=%h/%h fall=%h/%h", c,
                         sw_if.sw_clean, m_clean, sw_if.sw_rise, m_rise, sw_if.sw_fall, m_fall);
            end
            r = int'($urandom_range(0, 11));
            if (r < 3) begin
                sw_if.sw_raw[$urandom_range(0, W - 1)] ^= 1'b1;
            end else if (r == 3) begin
                sw_if.sw_raw = W'($urandom);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sw_if.sw_raw = '0;
        reset = 1'b0;
        #2;
        test_reset();
        test_single_rise();
        test_glitch();
        test_bounce();
        test_staggered();
        test_random();
        test_reset_mid_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
